// File: rtl/alu_multiciclo.sv
// Purpose  : registered WIDTH-bit ALU (arith/logic groups, Z/C/S flags) with an
//            iterative shift-add unsigned multiply producing a double-width product.
// Latency  : simple ops 1 clock (start edge -> done); multiply WIDTH clocks.
// Backpr.  : start is only sampled while busy=0; starts during a multiply are dropped.
// Ports    : clk/reset (async, active-high); start, A, B, Op, l in;
//            R (low result), Rh (product high half), z/c/s flags, busy, done out.
// Option   : define ALU_OVERFLOW_EN to add the registered signed-overflow flag v.
module alu_multiciclo #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             l,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Rh,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             busy,
    output logic             done
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             v
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH-1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     rh_q, rh_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 s_q, s_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef ALU_OVERFLOW_EN
    logic                 v_q, v_d;
    logic                 alu_v;
`endif

    // Single-cycle result path, evaluated on the live operands.
    logic [WIDTH:0]       alu_ext;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_s;
    logic                 alu_z;

    // Multiply step: the low half of acc starts as the multiplier and is shifted
    // out one bit per clock while the partial product grows into the high half.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic                 is_mul;

    assign is_mul = !l && (Op == 3'b100);

    always_comb begin
        alu_ext = '0;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_s   = 1'b0;
`ifdef ALU_OVERFLOW_EN
        alu_v   = 1'b0;
`endif
        if (!l) begin
            case (Op)
                3'b000:  alu_ext = {1'b0, A} + {1'b0, ~B} + ONE_X;
                3'b001:  alu_ext = {1'b0, A} + {1'b0, B};
                3'b010:  alu_ext = {1'b0, ~B} + ONE_X;
                3'b011:  alu_ext = {1'b0, ~A} + ONE_X;
                // 100 takes the multiply path; 101..111 are reserved and yield zero.
                default: alu_ext = '0;
            endcase
            alu_r = alu_ext[WIDTH-1:0];
            alu_c = alu_ext[WIDTH];
            alu_s = alu_ext[WIDTH-1];
`ifdef ALU_OVERFLOW_EN
            case (Op)
                3'b000:  alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_ext[WIDTH-1] != A[WIDTH-1]);
                3'b001:  alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_ext[WIDTH-1] != A[WIDTH-1]);
                // Negating the most negative value is the only overflowing case.
                3'b010:  alu_v = (B == MIN_NEG);
                3'b011:  alu_v = (A == MIN_NEG);
                default: alu_v = 1'b0;
            endcase
`endif
        end else begin
            case (Op)
                3'b000:  alu_r = A & B;
                3'b001:  alu_r = A | B;
                3'b010:  alu_r = A ^ B;
                3'b011:  alu_r = ~A;
                default: alu_r = '0;
            endcase
        end
        alu_z = ~|alu_r;
    end

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        r_d     = r_q;
        rh_d    = rh_q;
        z_d     = z_q;
        c_d     = c_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ALU_OVERFLOW_EN
        v_d     = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        mcand_d = A;
                        acc_d   = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_MUL;
                    end else begin
                        r_d    = alu_r;
                        rh_d   = '0;
                        z_d    = alu_z;
                        c_d    = alu_c;
                        s_d    = alu_s;
                        done_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
                        v_d    = alu_v;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                cnt_d = cnt_q + 1'b1;
                // The WIDTH-th step both finishes the product and publishes it.
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    r_d     = mul_acc[WIDTH-1:0];
                    rh_d    = mul_acc[2*WIDTH-1:WIDTH];
                    c_d     = |mul_acc[2*WIDTH-1:WIDTH];
                    s_d     = mul_acc[WIDTH-1];
                    z_d     = ~|mul_acc;
`ifdef ALU_OVERFLOW_EN
                    v_d     = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            rh_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            rh_q    <= rh_d;
            z_q     <= z_d;
            c_q     <= c_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign R    = r_q;
    assign Rh   = rh_q;
    assign z    = z_q;
    assign c    = c_q;
    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef ALU_OVERFLOW_EN
    assign v    = v_q;
`endif

endmodule

// File: tb/tb_alu_multiciclo.sv
// Purpose  : directed and exhaustive self-checking bench for alu_multiciclo (WIDTH=4).
// Latency  : inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpr.  : exercises starts issued while a multiply is busy.
module tb_alu_multiciclo;
    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Op;
    logic         l;
    logic [W-1:0] R;
    logic [W-1:0] Rh;
    logic         z;
    logic         c;
    logic         s;
    logic         busy;
    logic         done;
`ifdef ALU_OVERFLOW_EN
    logic         v;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .l     (l),
        .R     (R),
        .Rh    (Rh),
        .z     (z),
        .c     (c),
        .s     (s),
        .busy  (busy),
        .done  (done)
`ifdef ALU_OVERFLOW_EN
        ,
        .v     (v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int r, input int rh, input int zz,
                           input int cc, input int ss, input int bz, input int dn);
        chk({tag, ".R"},    int'(R),    r);
        chk({tag, ".Rh"},   int'(Rh),   rh);
        chk({tag, ".z"},    int'(z),    zz);
        chk({tag, ".c"},    int'(c),    cc);
        chk({tag, ".s"},    int'(s),    ss);
        chk({tag, ".busy"}, int'(busy), bz);
        chk({tag, ".done"}, int'(done), dn);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ll, input int op, input int a, input int b);
        l  = ll[0];
        Op = op[2:0];
        A  = a[W-1:0];
        B  = b[W-1:0];
    endtask

    // Start a multiply and walk through its busy window; caller checks the result.
    task automatic run_mul(input string tag, input int a, input int b);
        drive(0, 4, a, b);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < W - 1; k++) begin
            chk({tag, ".busy"}, int'(busy), 1);
            chk({tag, ".done"}, int'(done), 0);
            tick;
        end
        chk({tag, ".busy_last"}, int'(busy), 1);
        tick;
    endtask

    // Reference written in plain integer arithmetic over 16-valued operands.
    task automatic ref_model(input int ll, input int op, input int a, input int b,
                             output int r, output int cc, output int ss,
                             output int zz, output int vv);
        int full;
        int sa;
        int sb;
        int res;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        r = 0; cc = 0; ss = 0; vv = 0;
        if (ll != 0) begin
            case (op)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                default: r = 15 - a;
            endcase
        end else begin
            case (op)
                0: begin full = a + 16 - b; res = sa - sb; end
                1: begin full = a + b;      res = sa + sb; end
                2: begin full = 16 - b;     res = -sb;     end
                default: begin full = 16 - a; res = -sa;   end
            endcase
            r  = full % 16;
            cc = full / 16;
            ss = (r >= 8) ? 1 : 0;
            vv = (res > 7 || res < -8) ? 1 : 0;
        end
        zz = (r == 0) ? 1 : 0;
    endtask

    initial begin
        int er;
        int ec;
        int es;
        int ez;
        int ev;

        reset = 1'b1;
        start = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
`ifdef ALU_OVERFLOW_EN
        chk("reset.v", int'(v), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Async reset mid-run: outputs must clear before any clock edge.
        drive(0, 1, 15, 15);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_out("add_ff", 14, 0, 0, 1, 1, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk_out("arst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // First start after reset: subtract.
        drive(0, 0, 5, 3);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_out("sub", 2, 0, 0, 1, 0, 0, 1);
        tick;
        chk("sub_hold.done", int'(done), 0);
        chk("sub_hold.R", int'(R), 2);

        // Back-to-back: add wrapping to zero, then logic NOT.
        drive(0, 1, 9, 7);
        start = 1'b1;
        tick;
        chk_out("add_wrap", 0, 0, 1, 1, 0, 0, 1);
        drive(1, 3, 10, 0);
        tick;
        start = 1'b0;
        chk_out("not", 5, 0, 0, 0, 0, 0, 1);
        tick;
        chk("not_hold.done", int'(done), 0);
        chk("not_hold.R", int'(R), 5);

        // 15*15 with a start pulse and operand change while busy.
        drive(0, 4, 15, 15);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("mul15.busy0", int'(busy), 1);
        chk("mul15.hold_R", int'(R), 5);
        for (int k = 1; k < W; k++) begin
            if (k == 1) begin
                drive(0, 1, 3, 2);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick;
            chk("mul15.busy", int'(busy), 1);
            chk("mul15.done_early", int'(done), 0);
            chk("mul15.hold_R2", int'(R), 5);
        end
        start = 1'b0;
        tick;
        chk_out("mul15", 1, 14, 0, 1, 0, 0, 1);
        tick;
        chk("mul15_after.done", int'(done), 0);
        chk("mul15_after.Rh", int'(Rh), 14);
        chk("mul15_after.busy", int'(busy), 0);

        run_mul("mul13x11", 13, 11);
        chk_out("mul13x11", 15, 8, 0, 1, 1, 0, 1);
        run_mul("mul0x9", 0, 9);
        chk_out("mul0x9", 0, 0, 1, 0, 0, 0, 1);
        run_mul("mul8x2", 8, 2);
        chk_out("mul8x2", 0, 1, 0, 1, 0, 0, 1);

        // Reset during the second cycle of a multiply.
        drive(0, 4, 15, 15);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        chk_out("mul_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("mul_rst_after.done", int'(done), 0);
            chk("mul_rst_after.busy", int'(busy), 0);
        end

        // Simple op right after an aborted multiply; reserved op afterwards.
        drive(1, 0, 12, 10);
        start = 1'b1;
        tick;
        chk_out("and", 8, 0, 0, 0, 0, 0, 1);
        drive(0, 6, 7, 7);
        tick;
        start = 1'b0;
        chk_out("reserved", 0, 0, 1, 0, 0, 0, 1);

`ifdef ALU_OVERFLOW_EN
        drive(0, 1, 7, 1);
        start = 1'b1;
        tick;
        chk_out("ovf_add", 8, 0, 0, 0, 1, 0, 1);
        chk("ovf_add.v", int'(v), 1);
        drive(0, 3, 8, 0);
        tick;
        start = 1'b0;
        chk_out("ovf_neg", 8, 0, 0, 0, 1, 0, 1);
        chk("ovf_neg.v", int'(v), 1);
`endif

        // Exhaustive sweep of single-cycle ops, issued back to back.
        start = 1'b1;
        for (int ll = 0; ll < 2; ll++) begin
            for (int op = 0; op < 4; op++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        drive(ll, op, a, b);
                        tick;
                        ref_model(ll, op, a, b, er, ec, es, ez, ev);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d R", ll, op, a, b), int'(R), er);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d c", ll, op, a, b), int'(c), ec);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d s", ll, op, a, b), int'(s), es);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d z", ll, op, a, b), int'(z), ez);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d done", ll, op, a, b), int'(done), 1);
                        chk($sformatf("sw l%0d op%0d a%0d b%0d Rh", ll, op, a, b), int'(Rh), 0);
`ifdef ALU_OVERFLOW_EN
                        chk($sformatf("sw l%0d op%0d a%0d b%0d v", ll, op, a, b), int'(v), ev);
`endif
                    end
                end
            end
        end
        start = 1'b0;
        tick;
        chk("sweep_end.done", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
